int_wb_collector: RTL and testbench
===================================

# int_wb_collector

Receiving end of an integer execution unit's `iresp` writeback port. It captures every valid response, since the port has no backpressure, into a small in-order FIFO. It drains the FIFO into one integer register-file write port, which a higher-priority writer can take away cycle by cycle. It signals ROB completion for every drained entry and raises an issue-stall while occupancy is high, so the FIFO never overflows in a correctly configured core. It sits between the execution unit and the integer register file / ROB writeback network.

## Interface
Parameters:
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `STALL_THRESH`, default 2: `io_stall` asserts when occupancy ≥ this value; 1..`DEPTH`.

Ports:
- `clock`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset; state clears immediately on assertion.
- `io_iresp_valid`  in  1  response valid; no ready exists.
- `io_iresp_bits_uop_rob_idx`  in  7  ROB index of the response.
- `io_iresp_bits_uop_pdst`  in  7  physical destination register.
- `io_iresp_bits_uop_dst_rtype`  in  2  destination type: 0 = FIX, 1 = FLT, 2 = X (none), 3 = PAS.
- `io_iresp_bits_data`  in  65  result data.
- `io_wport_grant`  in  1  register-file write port is free this cycle.
- `io_wport_valid`  out  1  write request.
- `io_wport_addr`  out  7  write address (pdst).
- `io_wport_data`  out  65  write data.
- `io_rob_wb_valid`  out  1  ROB completion strobe.
- `io_rob_wb_rob_idx`  out  7  ROB index being completed.
- `io_stall`  out  1  issue must stop sending to the execution unit.
- `io_count`  out  clog2(`DEPTH`)+1  current occupancy.
- `io_overflow`  out  1  sticky error flag.

## Operation
- Storage: circular FIFO with head pointer, tail pointer and count registers. Each entry holds rob_idx, pdst, dst_rtype and data; the data field is 65 bits and is stored unmodified.
- Head status:
  - head_valid = count ≠ 0.
  - needs_write = (head dst_rtype == 0).
- Drain (combinational from head):
  - `io_wport_valid` = head_valid & needs_write.
  - pop = head_valid & (~needs_write | `io_wport_grant`).
  - `io_rob_wb_valid` = pop; `io_rob_wb_rob_idx` = head rob_idx.
  - Entries with dst_rtype 1, 2 or 3 never write the register file; they complete to the ROB without waiting for grant.
- Output gating: `io_wport_addr`/`io_wport_data` are 0 whenever `io_wport_valid` = 0, and `io_rob_wb_rob_idx` is 0 whenever `io_rob_wb_valid` = 0. Storage itself is not reset.
- Enqueue: push = `io_iresp_valid` & (count < `DEPTH` | pop).
  - On push: the entry is written at tail and tail increments modulo `DEPTH`.
  - On pop: head increments modulo `DEPTH`.
  - Count update: count += push − pop.
- Overflow: `io_iresp_valid` while count == `DEPTH` and no pop drops the response and sets `io_overflow`. The flag stays set until reset.
- Stall: `io_stall` = (count ≥ `STALL_THRESH`), decoded from the count register.
- Strict in-order drain: a FIX entry blocked on grant also blocks younger non-FIX entries behind it.

## Timing
- Reset values: count, head, tail and overflow are 0. All outputs are 0 during and immediately after reset.
- Latency: a response arriving in cycle N is stored at the edge ending N. It appears at head in N+1 at the earliest. There is no same-cycle bypass.
- Throughput: one pop per cycle when grant is held high (or entries are non-FIX); one push per cycle.
- Full with simultaneous pop: the push is accepted, count stays at `DEPTH`, no overflow.
- Empty with push: pop is 0 that cycle; count becomes 1.
- Pointer wrap: pointers wrap from `DEPTH`−1 to 0 with no bubble.
- Grant toggling: a FIX head holds its outputs stable until the cycle in which grant = 1. It pops in that same cycle.
- Reset asserted mid-operation: all contents are discarded, no completion strobe is emitted, and the flag clears.

## Test plan
- Single FIX entry: iresp rob_idx=0x05, pdst=0x12, data=0x1_0000_0000_0000_00AB in cycle 0, grant=1. Required in cycle 1: wport_valid=1, addr=0x12, data=0x1_0000_0000_0000_00AB, rob_wb_valid=1, rob_idx=0x05. Required in cycle 2: count=0.
- Grant withheld: 3 FIX entries in back-to-back cycles with grant=0. Required: count reaches 3 and io_stall=1 from the cycle count=2. Then grant=1: pops in ROB order over 3 consecutive cycles, stall drops once count<2.
- Non-FIX bypasses grant: a dst_rtype=2 entry with grant=0 → rob_wb_valid=1 next cycle and wport_valid=0. A FIX head with grant=0 followed by an X entry → the X entry does not complete until the FIX entry pops.
- Full plus simultaneous pop: fill 4 entries with grant=0. Then hold grant=1 with iresp valid every cycle. Required: count stays 4, overflow stays 0, and pointers wrap correctly (rob_idx sequence continuous).
- Overflow: fill 4 entries with grant=0, then one more valid → response dropped, io_overflow=1 and it stays set after draining.
- Async reset: assert reset low mid-cycle with count=3 → all outputs 0 immediately. After release, the first new response drains normally.

Source files
------------

// File: rtl/int_wb_collector.sv
// Integer writeback collector: buffers iresp results in order and drains
// them into one register-file write port plus the ROB completion network.
module int_wb_collector #(
    parameter int DEPTH        = 4,
    parameter int STALL_THRESH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     io_iresp_valid,
    input  logic [6:0]               io_iresp_bits_uop_rob_idx,
    input  logic [6:0]               io_iresp_bits_uop_pdst,
    input  logic [1:0]               io_iresp_bits_uop_dst_rtype,
    input  logic [64:0]              io_iresp_bits_data,
    input  logic                     io_wport_grant,
    output logic                     io_wport_valid,
    output logic [6:0]               io_wport_addr,
    output logic [64:0]              io_wport_data,
    output logic                     io_rob_wb_valid,
    output logic [6:0]               io_rob_wb_rob_idx,
    output logic                     io_stall,
    output logic [$clog2(DEPTH):0]   io_count,
    output logic                     io_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [6:0]    r_rob   [DEPTH];
    logic [6:0]    r_pdst  [DEPTH];
    logic [1:0]    r_rtype [DEPTH];
    logic [64:0]   r_data  [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    logic          w_head_valid;
    logic          w_needs_write;
    logic          w_pop;
    logic          w_push;
    logic          w_full;

    assign w_head_valid  = (r_count != '0);
    assign w_needs_write = (r_rtype[r_head] == 2'd0);
    assign w_full        = (r_count == CW'(DEPTH));
    assign w_pop         = w_head_valid & (~w_needs_write | io_wport_grant);
    assign w_push        = io_iresp_valid & (~w_full | w_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + AW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (io_iresp_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Payload storage carries no reset; occupancy alone qualifies it.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_rob[r_tail]   <= io_iresp_bits_uop_rob_idx;
            r_pdst[r_tail]  <= io_iresp_bits_uop_pdst;
            r_rtype[r_tail] <= io_iresp_bits_uop_dst_rtype;
            r_data[r_tail]  <= io_iresp_bits_data;
        end
    end

    assign io_wport_valid    = w_head_valid & w_needs_write;
    assign io_wport_addr     = io_wport_valid ? r_pdst[r_head] : 7'd0;
    assign io_wport_data     = io_wport_valid ? r_data[r_head] : 65'd0;
    assign io_rob_wb_valid   = w_pop;
    assign io_rob_wb_rob_idx = w_pop ? r_rob[r_head] : 7'd0;
    assign io_stall          = (r_count >= CW'(STALL_THRESH));
    assign io_count          = r_count;
    assign io_overflow       = r_overflow;

endmodule

// File: tb/tb_int_wb_collector.sv
// Directed vector bench for int_wb_collector (DEPTH=4, STALL_THRESH=2).
module tb_int_wb_collector;

    logic        clock;
    logic        reset;
    logic        iv;
    logic [6:0]  irob;
    logic [6:0]  ipdst;
    logic [1:0]  irt;
    logic [64:0] idata;
    logic        grant;
    logic        wv;
    logic [6:0]  waddr;
    logic [64:0] wdata;
    logic        rv;
    logic [6:0]  ridx;
    logic        stall;
    logic [2:0]  count;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    int_wb_collector #(.DEPTH(4), .STALL_THRESH(2)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .io_iresp_valid              (iv),
        .io_iresp_bits_uop_rob_idx   (irob),
        .io_iresp_bits_uop_pdst      (ipdst),
        .io_iresp_bits_uop_dst_rtype (irt),
        .io_iresp_bits_data          (idata),
        .io_wport_grant              (grant),
        .io_wport_valid              (wv),
        .io_wport_addr               (waddr),
        .io_wport_data               (wdata),
        .io_rob_wb_valid             (rv),
        .io_rob_wb_rob_idx           (ridx),
        .io_stall                    (stall),
        .io_count                    (count),
        .io_overflow                 (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [6:0]  rob;
        logic [6:0]  pdst;
        logic [1:0]  rt;
        logic [64:0] data;
        logic        g;
        logic        ewv;
        logic [6:0]  eaddr;
        logic [64:0] edata;
        logic        erv;
        logic [6:0]  eridx;
        logic        estall;
        logic [2:0]  ecnt;
        logic        eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [64:0] dfn(input logic [6:0] r);
        return {1'b1, 8'hC3, 48'h0, 1'b0, r};
    endfunction

    task automatic add(
        input logic v, input logic [6:0] rob, input logic [6:0] pdst,
        input logic [1:0] rt, input logic [64:0] data, input logic g,
        input logic ewv, input logic [6:0] eaddr, input logic [64:0] edata,
        input logic erv, input logic [6:0] eridx, input logic estall,
        input logic [2:0] ecnt, input logic eovf);
        vec_t t;
        t.v = v; t.rob = rob; t.pdst = pdst; t.rt = rt; t.data = data;
        t.g = g; t.ewv = ewv; t.eaddr = eaddr; t.edata = edata;
        t.erv = erv; t.eridx = eridx; t.estall = estall;
        t.ecnt = ecnt; t.eovf = eovf;
        vecs.push_back(t);
    endtask

    // Shorthand for a cycle with no response presented.
    task automatic idle(
        input logic g, input logic ewv, input logic [6:0] eaddr,
        input logic [64:0] edata, input logic erv, input logic [6:0] eridx,
        input logic estall, input logic [2:0] ecnt, input logic eovf);
        add(1'b0, 7'd0, 7'd0, 2'd0, 65'd0, g,
            ewv, eaddr, edata, erv, eridx, estall, ecnt, eovf);
    endtask

    task automatic chk(input string name, input logic [64:0] act,
                       input logic [64:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ewv,
        input logic [6:0] eaddr, input logic [64:0] edata, input logic erv,
        input logic [6:0] eridx, input logic estall, input logic [2:0] ecnt,
        input logic eovf);
        chk({tag, ".wv"},    65'(wv),    65'(ewv));
        chk({tag, ".addr"},  65'(waddr), 65'(eaddr));
        chk({tag, ".wdata"}, wdata,      edata);
        chk({tag, ".rv"},    65'(rv),    65'(erv));
        chk({tag, ".ridx"},  65'(ridx),  65'(eridx));
        chk({tag, ".stall"}, 65'(stall), 65'(estall));
        chk({tag, ".count"}, 65'(count), 65'(ecnt));
        chk({tag, ".ovf"},   65'(ovf),   65'(eovf));
    endtask

    task automatic drive(input logic v, input logic [6:0] rob,
        input logic [6:0] pdst, input logic [1:0] rt,
        input logic [64:0] data, input logic g);
        iv = v; irob = rob; ipdst = pdst; irt = rt; idata = data; grant = g;
    endtask

    logic [64:0] d_ab;

    initial begin
        d_ab = 65'h1_0000_0000_0000_00AB;

        // Single FIX entry
        add(1, 7'h05, 7'h12, 0, d_ab, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 1, 7'h12, d_ab, 1, 7'h05, 0, 1, 0);
        idle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // Grant withheld, three FIX entries, then drain
        add(1, 7'h10, 7'h20, 0, dfn(7'h10), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 7'h11, 7'h21, 0, dfn(7'h11), 0,
            1, 7'h20, dfn(7'h10), 0, 0, 0, 1, 0);
        add(1, 7'h12, 7'h22, 0, dfn(7'h12), 0,
            1, 7'h20, dfn(7'h10), 0, 0, 1, 2, 0);
        idle(0, 1, 7'h20, dfn(7'h10), 0, 0, 1, 3, 0);
        idle(1, 1, 7'h20, dfn(7'h10), 1, 7'h10, 1, 3, 0);
        idle(1, 1, 7'h21, dfn(7'h11), 1, 7'h11, 1, 2, 0);
        idle(1, 1, 7'h22, dfn(7'h12), 1, 7'h12, 0, 1, 0);
        idle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Non-FIX completes without grant
        add(1, 7'h30, 7'h31, 2, dfn(7'h30), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(0, 0, 0, 0, 1, 7'h30, 0, 1, 0);
        // FIX head blocks younger X entry
        add(1, 7'h40, 7'h41, 0, dfn(7'h40), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 7'h42, 7'h43, 2, dfn(7'h42), 0,
            1, 7'h41, dfn(7'h40), 0, 0, 0, 1, 0);
        idle(0, 1, 7'h41, dfn(7'h40), 0, 0, 1, 2, 0);
        idle(1, 1, 7'h41, dfn(7'h40), 1, 7'h40, 1, 2, 0);
        idle(0, 0, 0, 0, 1, 7'h42, 0, 1, 0);
        idle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Full plus simultaneous pop, pointer wrap
        add(1, 7'h50, 7'h60, 0, dfn(7'h50), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 7'h51, 7'h61, 0, dfn(7'h51), 0,
            1, 7'h60, dfn(7'h50), 0, 0, 0, 1, 0);
        add(1, 7'h52, 7'h62, 0, dfn(7'h52), 0,
            1, 7'h60, dfn(7'h50), 0, 0, 1, 2, 0);
        add(1, 7'h53, 7'h63, 0, dfn(7'h53), 0,
            1, 7'h60, dfn(7'h50), 0, 0, 1, 3, 0);
        add(1, 7'h54, 7'h64, 0, dfn(7'h54), 1,
            1, 7'h60, dfn(7'h50), 1, 7'h50, 1, 4, 0);
        add(1, 7'h55, 7'h65, 0, dfn(7'h55), 1,
            1, 7'h61, dfn(7'h51), 1, 7'h51, 1, 4, 0);
        add(1, 7'h56, 7'h66, 0, dfn(7'h56), 1,
            1, 7'h62, dfn(7'h52), 1, 7'h52, 1, 4, 0);
        idle(1, 1, 7'h63, dfn(7'h53), 1, 7'h53, 1, 4, 0);
        idle(1, 1, 7'h64, dfn(7'h54), 1, 7'h54, 1, 3, 0);
        idle(1, 1, 7'h65, dfn(7'h55), 1, 7'h55, 1, 2, 0);
        idle(1, 1, 7'h66, dfn(7'h56), 1, 7'h56, 0, 1, 0);
        idle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Overflow: fifth response dropped, flag sticky
        add(1, 7'h70, 7'h78, 0, dfn(7'h70), 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 7'h71, 7'h79, 0, dfn(7'h71), 0,
            1, 7'h78, dfn(7'h70), 0, 0, 0, 1, 0);
        add(1, 7'h72, 7'h7A, 0, dfn(7'h72), 0,
            1, 7'h78, dfn(7'h70), 0, 0, 1, 2, 0);
        add(1, 7'h73, 7'h7B, 0, dfn(7'h73), 0,
            1, 7'h78, dfn(7'h70), 0, 0, 1, 3, 0);
        add(1, 7'h74, 7'h7C, 0, dfn(7'h74), 0,
            1, 7'h78, dfn(7'h70), 0, 0, 1, 4, 0);
        idle(0, 1, 7'h78, dfn(7'h70), 0, 0, 1, 4, 1);
        idle(1, 1, 7'h78, dfn(7'h70), 1, 7'h70, 1, 4, 1);
        idle(1, 1, 7'h79, dfn(7'h71), 1, 7'h71, 1, 3, 1);
        idle(1, 1, 7'h7A, dfn(7'h72), 1, 7'h72, 1, 2, 1);
        idle(1, 1, 7'h7B, dfn(7'h73), 1, 7'h73, 0, 1, 1);
        idle(0, 0, 0, 0, 0, 0, 0, 0, 1);

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_all("in_reset", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clock);
            drive(vecs[i].v, vecs[i].rob, vecs[i].pdst, vecs[i].rt,
                  vecs[i].data, vecs[i].g);
            #1;
            chk_all($sformatf("vec%0d", i), vecs[i].ewv, vecs[i].eaddr,
                    vecs[i].edata, vecs[i].erv, vecs[i].eridx,
                    vecs[i].estall, vecs[i].ecnt, vecs[i].eovf);
        end

        // Async reset with three entries held
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            drive(1, 7'(k), 7'(k + 8), 0, dfn(7'(k)), 0);
        end
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("rst_pre.count", 65'(count), 65'd3);
        chk("rst_pre.ovf", 65'(ovf), 65'd1);
        #1;
        grant = 1'b1;
        reset = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        grant = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        drive(1, 7'h09, 7'h19, 0, dfn(7'h09), 1);
        #1;
        chk_all("rst_new0", 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 1);
        #1;
        chk_all("rst_new1", 1, 7'h19, dfn(7'h09), 1, 7'h09, 0, 1, 0);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk_all("rst_new2", 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
